// File: rtl/cga_sync_monitor.sv
// cga_sync_monitor: measures CGA raster timing (line/frame lengths, active extents) and reports lock.
// Optional feature macro CGA_SYNC_MON_TOL_EN: accept +/-1 clock of line-length jitter between frames.
module cga_sync_monitor #(
   parameter int unsigned LOCK_FRAMES = 2,
   parameter logic [23:0] TIMEOUT     = 24'd4_000_000
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        display_enable,
   output logic [11:0] h_period,
   output logic [11:0] h_active,
   output logic [9:0]  v_lines,
   output logic [9:0]  v_active,
   output logic        locked,
   output logic        no_signal,
   output logic        mode_change
);
   localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {NOSIG, ACQUIRE, LOCKED} state_t;
   state_t state_q, state_d;

   logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic        hs_rise, vs_rise, len_ok, cand_eq;
   logic [11:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d;
   logic [11:0] line_len_q, line_len_d, line_de_q, line_de_d;
   logic [9:0]  l_cnt_q, l_cnt_d, a_cnt_q, a_cnt_d, l_upd, a_upd;
   logic [11:0] pc_len_q, pc_len_d, pc_de_q, pc_de_d;
   logic [9:0]  pc_lines_q, pc_lines_d, pc_act_q, pc_act_d;
   logic [3:0]  match_q, match_d, match_inc;
   logic [23:0] to_cnt_q, to_cnt_d;
   logic [11:0] h_period_q, h_period_d, h_active_q, h_active_d;
   logic [9:0]  v_lines_q, v_lines_d, v_active_q, v_active_d;
   logic        mode_change_q, mode_change_d;

   // Line measurement and sync timeout
   always_comb begin
      hs_d      = hsync;
      vs_d      = vsync;
      de_d      = display_enable;
      hs_prev_d = hs_q;
      vs_prev_d = vs_q;
      hs_rise   = hs_q & ~hs_prev_q;
      vs_rise   = vs_q & ~vs_prev_q;

      h_cnt_d    = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1;
      de_cnt_d   = (de_q && de_cnt_q != '1) ? de_cnt_q + 12'd1 : de_cnt_q;
      line_len_d = line_len_q;
      line_de_d  = line_de_q;
      l_upd      = l_cnt_q;
      a_upd      = a_cnt_q;
      to_cnt_d   = (to_cnt_q == TIMEOUT) ? to_cnt_q : to_cnt_q + 24'd1;

      if (hs_rise) begin
         line_len_d = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1;
         line_de_d  = de_cnt_q;
         h_cnt_d    = '0;
         de_cnt_d   = '0;
         to_cnt_d   = '0;
         l_upd      = (l_cnt_q == '1) ? l_cnt_q : l_cnt_q + 10'd1;
         if (de_cnt_q != '0)
            a_upd = (a_cnt_q == '1) ? a_cnt_q : a_cnt_q + 10'd1;
      end
   end

`ifdef CGA_SYNC_MON_TOL_EN
   logic [12:0] len_w, pc_w;
   always_comb begin
      len_w  = {1'b0, line_len_d};
      pc_w   = {1'b0, pc_len_q};
      len_ok = (len_w == pc_w) || (len_w == pc_w + 13'd1) || (len_w + 13'd1 == pc_w);
   end
`else
   assign len_ok = (line_len_d == pc_len_q);
`endif

   // Frame close uses post-hsync values so a coincident hsync line lands in the closing frame
   always_comb begin
      cand_eq   = len_ok && (line_de_d == pc_de_q) && (l_upd == pc_lines_q) && (a_upd == pc_act_q);
      match_inc = (match_q >= LOCK_N) ? LOCK_N : match_q + 4'd1;

      state_d       = state_q;
      match_d       = match_q;
      pc_len_d      = pc_len_q;
      pc_de_d       = pc_de_q;
      pc_lines_d    = pc_lines_q;
      pc_act_d      = pc_act_q;
      h_period_d    = h_period_q;
      h_active_d    = h_active_q;
      v_lines_d     = v_lines_q;
      v_active_d    = v_active_q;
      mode_change_d = 1'b0;
      l_cnt_d       = l_upd;
      a_cnt_d       = a_upd;

      if (vs_rise) begin
         pc_len_d   = line_len_d;
         pc_de_d    = line_de_d;
         pc_lines_d = l_upd;
         pc_act_d   = a_upd;
         l_cnt_d    = '0;
         a_cnt_d    = '0;
         case (state_q)
            NOSIG: begin
               state_d = ACQUIRE;
               match_d = '0;
            end
            ACQUIRE: begin
               match_d = cand_eq ? match_inc : '0;
               if (cand_eq && match_inc == LOCK_N) begin
                  state_d    = LOCKED;
                  h_period_d = line_len_d;
                  h_active_d = line_de_d;
                  v_lines_d  = l_upd;
                  v_active_d = a_upd;
               end
            end
            LOCKED: begin
               if (cand_eq) begin
                  match_d = match_inc;
               end else begin
                  match_d       = '0;
                  mode_change_d = 1'b1;
                  state_d       = ACQUIRE;
               end
            end
            default: state_d = NOSIG;
         endcase
      end

      // Loss of signal overrides any frame decision, without a mode-change pulse
      if (to_cnt_d == TIMEOUT) begin
         state_d       = NOSIG;
         mode_change_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state_q       <= NOSIG;
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         de_q          <= 1'b0;
         hs_prev_q     <= 1'b0;
         vs_prev_q     <= 1'b0;
         h_cnt_q       <= '0;
         de_cnt_q      <= '0;
         line_len_q    <= '0;
         line_de_q     <= '0;
         l_cnt_q       <= '0;
         a_cnt_q       <= '0;
         pc_len_q      <= '0;
         pc_de_q       <= '0;
         pc_lines_q    <= '0;
         pc_act_q      <= '0;
         match_q       <= '0;
         to_cnt_q      <= '0;
         h_period_q    <= '0;
         h_active_q    <= '0;
         v_lines_q     <= '0;
         v_active_q    <= '0;
         mode_change_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         de_q          <= de_d;
         hs_prev_q     <= hs_prev_d;
         vs_prev_q     <= vs_prev_d;
         h_cnt_q       <= h_cnt_d;
         de_cnt_q      <= de_cnt_d;
         line_len_q    <= line_len_d;
         line_de_q     <= line_de_d;
         l_cnt_q       <= l_cnt_d;
         a_cnt_q       <= a_cnt_d;
         pc_len_q      <= pc_len_d;
         pc_de_q       <= pc_de_d;
         pc_lines_q    <= pc_lines_d;
         pc_act_q      <= pc_act_d;
         match_q       <= match_d;
         to_cnt_q      <= to_cnt_d;
         h_period_q    <= h_period_d;
         h_active_q    <= h_active_d;
         v_lines_q     <= v_lines_d;
         v_active_q    <= v_active_d;
         mode_change_q <= mode_change_d;
      end
   end

   assign h_period    = h_period_q;
   assign h_active    = h_active_q;
   assign v_lines     = v_lines_q;
   assign v_active    = v_active_q;
   assign locked      = (state_q == LOCKED);
   assign no_signal   = (state_q == NOSIG);
   assign mode_change = mode_change_q;
endmodule

// File: doc/cga_sync_monitor.md
# cga_sync_monitor

Measures the raster timing produced by the CGA core: clocks per line, active clocks per line, lines per frame, and active lines per frame. It sits directly downstream of the `cga` top level, tapping `hsync`, `vsync` (non-inverted) and `display_enable`. It publishes frame-stable measurements and a lock status, so the output scaler and the status logic can detect mode changes and loss of signal.

## Interface
- `LOCK_FRAMES`, default 2: consecutive identical frames required to declare lock (1..15).
- `TIMEOUT`, default 24'd4_000_000: clocks without an hsync rising edge before entering NOSIG.
- `clk` input 1: pixel/system clock, the same clock that drives `cga`.
- `reset_l` input 1: synchronous, active-low reset.
- `hsync` input 1: active-high horizontal sync from the CRTC.
- `vsync` input 1: active-high vertical sync.
- `display_enable` input 1: high during active pixels.
- `h_period` output 12: clocks from one hsync rise to the next.
- `h_active` output 12: `display_enable`-high clocks within one line.
- `v_lines` output 10: hsync rises per frame.
- `v_active` output 10: lines per frame with nonzero `display_enable` count.
- `locked` output 1: measurements are stable and valid.
- `no_signal` output 1: timeout has expired or the block has just been reset.
- `mode_change` output 1: one-clock pulse when lock is lost through a mismatch.

## Operation
- All three inputs are registered once; edges are detected from the current registered sample against the previous one.
- Line counters:
  - `h_cnt` increments every clock and saturates at 4095.
  - `de_cnt` increments each clock `display_enable` is high and saturates at 4095.
  - On an hsync rise: `line_len <= h_cnt + 1` (saturating), `line_de <= de_cnt`; both counters clear; `l_cnt` increments (saturating at 1023); `a_cnt` increments if `de_cnt != 0`.
- Frame close on a vsync rise: candidate = {`line_len`, `line_de`, `l_cnt`, `a_cnt`}.
  - Candidate equals the previous candidate: `match_cnt` increments, saturating at `LOCK_FRAMES`.
  - Otherwise: `match_cnt` clears.
  - In both cases the previous candidate is updated, and `l_cnt` and `a_cnt` clear.
- Simultaneous hsync and vsync rise: the line is counted into the frame being closed first.
- State machine:
  - **NOSIG** (reset state). `no_signal=1`, `locked=0`. The first vsync rise goes to ACQUIRE. That first frame is partial; its candidate is stored and `match_cnt` is set to 0.
  - **ACQUIRE**. Each frame close performs the comparison. When `match_cnt` reaches `LOCK_FRAMES`, copy the candidate to the outputs, set `locked=1`, and go to LOCKED.
  - **LOCKED**. A matching frame leaves the outputs unchanged. A mismatch pulses `mode_change`, drops `locked`, clears `match_cnt`, and goes to ACQUIRE. The outputs hold their last locked values until relock.
  - **Any state**. A timeout counter, cleared on every hsync rise, reaching `TIMEOUT` goes to NOSIG. The `h_period`, `h_active`, `v_lines` and `v_active` outputs hold their values; `locked` drops; `mode_change` does not pulse.
- Reset values: `h_period`, `h_active`, `v_lines`, `v_active` = 0; `locked` = 0; `no_signal` = 1; `mode_change` = 0. All internal counters are 0.

## Timing
- Input-to-edge latency is 1 clock. Registered outputs update on the clock after the edge is detected.
- Net effect: outputs change on the 2nd rising `clk` edge at which the input is sampled high.
- `locked` rises in the same cycle that the output measurements update.
- `mode_change` is high for exactly one clock, coincident with `locked` falling.
- Timeout: `no_signal` rises `TIMEOUT + 1` clocks after the last registered hsync rise.
- Reset mid-frame: all state returns to NOSIG on the next clock. Partial counts are discarded.

## Configuration
- `CGA_SYNC_MON_TOL_EN` defined: the `line_len` comparison accepts a ±1 clock difference. This absorbs CRTC jitter from odd `H_TOTAL` values and register writes. `line_de`, `l_cnt` and `a_cnt` still compare exactly. On lock, the outputs take the newest candidate.
- `CGA_SYNC_MON_TOL_EN` undefined: all four fields compare exactly.

## Test plan
- **Reset:** assert `reset_l=0` for 3 clocks → `no_signal=1`, `locked=0`, all measurement outputs 0.
- **Lock:** drive 912-clock lines with 640 DE clocks and 262 lines/frame, 200 of them active, using `LOCK_FRAMES=2` → after the third full vsync rise `h_period=912`, `h_active=640`, `v_lines=262`, `v_active=200`, `locked=1`, `no_signal=0`.
- **Mode change:** while locked, switch DE to 320 clocks/line → at the next vsync rise `mode_change` pulses 1 clock, `locked=0`, outputs stay at 640. Relock occurs 2 frames later with `h_active=320`.
- **Timeout:** stop hsync with `TIMEOUT=1000` → `no_signal=1` and `locked=0` 1001 clocks after the last hsync rise; measurements are retained; no `mode_change`.
- **Simultaneous edges:** hsync and vsync rise on the same clock → that line is counted in the closing frame, so `v_lines=262`, not 261.
- **Tolerance:** alternate 912/913-clock lines at each frame end → with `CGA_SYNC_MON_TOL_EN` the block locks; without it `locked` stays 0.
